// File: rtl/config_stream_transmitter.sv
// config_stream_transmitter: collects host configuration frames byte by byte and
// replays each completed frame as one contiguous configId/configData burst, after
// tracing has been dropped and the datapath has had time to drain.
//
// Host handshake (cfg_valid/cfg_ready): a byte moves on a rising clk edge where
// both are high. cfg_ready depends only on registered state and reset, never on
// cfg_valid. While cfg_valid is high and cfg_ready is low, the host holds
// cfg_byte, cfg_target_id and cfg_last stable.
module config_stream_transmitter #(
  parameter logic [7:0] IDLE_ID        = 8'hFF,
  parameter int         BUF_DEPTH      = 128,
  parameter int         DESC_DEPTH     = 4,
  parameter int         MAX_FRAME      = 64,
  parameter int         QUIESCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_byte,
  input  logic [7:0] cfg_target_id,
  input  logic       cfg_last,
  input  logic       tracing_req,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam int BUF_AW  = $clog2(BUF_DEPTH);
  localparam int DESC_AW = $clog2(DESC_DEPTH);
  localparam int BCNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int DCNT_W  = $clog2(DESC_DEPTH + 1);
  localparam int LEN_W   = $clog2(MAX_FRAME + 1);
  localparam int QCNT_W  = $clog2(QUIESCE_CYCLES + 2);

  localparam logic [BCNT_W-1:0] BUF_FULL     = BCNT_W'(BUF_DEPTH);
  localparam logic [DCNT_W-1:0] DESC_FULL    = DCNT_W'(DESC_DEPTH);
  localparam logic [LEN_W-1:0]  MAX_LEN      = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0]  LEN_ONE      = LEN_W'(1);
  localparam logic [QCNT_W-1:0] QUIESCE_LOAD = QCNT_W'(QUIESCE_CYCLES);
  localparam logic [QCNT_W-1:0] QCNT_ONE     = QCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUIESCE = 2'd1,
    S_SEND    = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  // Byte buffer and descriptor FIFO storage (no reset needed: guarded by counts).
  logic [7:0]       buf_mem      [BUF_DEPTH];
  logic [7:0]       desc_id_mem  [DESC_DEPTH];
  logic [LEN_W-1:0] desc_len_mem [DESC_DEPTH];

  // FSM and bus output registers.
  state_t            state_q, state_d;
  logic [QCNT_W-1:0] qcnt_q, qcnt_d;
  logic [LEN_W-1:0]  send_cnt_q, send_cnt_d;
  logic [7:0]        cfg_id_q, cfg_id_d;
  logic [7:0]        cfg_data_q, cfg_data_d;
  logic              tracing_q, tracing_d;

  // Buffer / descriptor bookkeeping.
  logic [BUF_AW-1:0]  buf_wr_ptr_q, buf_wr_ptr_d;
  logic [BUF_AW-1:0]  buf_rd_ptr_q, buf_rd_ptr_d;
  logic [BCNT_W-1:0]  bytes_stored_q, bytes_stored_d;
  logic [DESC_AW-1:0] desc_wr_ptr_q, desc_wr_ptr_d;
  logic [DESC_AW-1:0] desc_rd_ptr_q, desc_rd_ptr_d;
  logic [DCNT_W-1:0]  frames_queued_q, frames_queued_d;

  // Frame currently being assembled from the host.
  logic             in_frame_q, in_frame_d;
  logic [7:0]       cur_id_q, cur_id_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic             frame_err_q, frame_err_d;

  logic             accept, first_byte, room, store, overflow, desc_push;
  logic [7:0]       frame_id;
  logic [LEN_W-1:0] frame_len;
  logic             buf_pop, desc_pop;
  logic [7:0]       head_id, head_byte;
  logic [LEN_W-1:0] head_len;

  assign cfg_ready  = !reset && (bytes_stored_q < BUF_FULL) && (frames_queued_q < DESC_FULL);
  assign head_id    = desc_id_mem[desc_rd_ptr_q];
  assign head_len   = desc_len_mem[desc_rd_ptr_q];
  assign head_byte  = buf_mem[buf_rd_ptr_q];

  assign tracing    = tracing_q;
  assign configId   = cfg_id_q;
  assign configData = cfg_data_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE) || (frames_queued_q != '0);
  assign state_dbg  = state_q;

  // Host side: latch target on the first byte, count length, drop bytes past MAX_FRAME.
  always_comb begin
    accept     = cfg_valid & cfg_ready;
    first_byte = !in_frame_q;
    room       = first_byte || (cur_len_q < MAX_LEN);
    store      = accept & room;
    overflow   = accept & !room;
    desc_push  = accept & cfg_last;
    frame_id   = first_byte ? cfg_target_id : cur_id_q;
    if (first_byte)  frame_len = LEN_ONE;
    else if (room)   frame_len = cur_len_q + LEN_ONE;
    else             frame_len = cur_len_q;

    in_frame_d  = in_frame_q;
    cur_id_d    = cur_id_q;
    cur_len_d   = cur_len_q;
    frame_err_d = frame_err_q | overflow;
    if (accept) begin
      in_frame_d = !cfg_last;
      cur_id_d   = frame_id;
      cur_len_d  = frame_len;
    end
  end

  // Sequencer: outputs are computed one cycle ahead so every bus signal is a flop.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    send_cnt_d = send_cnt_q;
    cfg_id_d   = IDLE_ID;
    cfg_data_d = 8'h00;
    tracing_d  = 1'b0;
    buf_pop    = 1'b0;
    desc_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tracing_d = tracing_req;
        // A frame completing this very cycle counts, so tracing drops at t+1.
        if ((frames_queued_q != '0) || desc_push) begin
          tracing_d = 1'b0;
          qcnt_d    = QUIESCE_LOAD;
          state_d   = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (qcnt_q == '0) begin
          buf_pop    = 1'b1;
          cfg_id_d   = head_id;
          cfg_data_d = head_byte;
          send_cnt_d = LEN_ONE;
          state_d    = S_SEND;
        end else begin
          qcnt_d = qcnt_q - QCNT_ONE;
        end
      end
      S_SEND: begin
        if (send_cnt_q < head_len) begin
          buf_pop    = 1'b1;
          cfg_id_d   = head_id;
          cfg_data_d = head_byte;
          send_cnt_d = send_cnt_q + LEN_ONE;
        end else begin
          desc_pop = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        // Pipeline is already drained, so a queued frame goes straight out.
        if (frames_queued_q != '0) begin
          buf_pop    = 1'b1;
          cfg_id_d   = head_id;
          cfg_data_d = head_byte;
          send_cnt_d = LEN_ONE;
          state_d    = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer and occupancy updates; simultaneous push and pop net out exactly.
  always_comb begin
    buf_wr_ptr_d    = buf_wr_ptr_q + BUF_AW'(store);
    buf_rd_ptr_d    = buf_rd_ptr_q + BUF_AW'(buf_pop);
    bytes_stored_d  = bytes_stored_q + BCNT_W'(store) - BCNT_W'(buf_pop);
    desc_wr_ptr_d   = desc_wr_ptr_q + DESC_AW'(desc_push);
    desc_rd_ptr_d   = desc_rd_ptr_q + DESC_AW'(desc_pop);
    frames_queued_d = frames_queued_q + DCNT_W'(desc_push) - DCNT_W'(desc_pop);
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      send_cnt_q <= '0;
      cfg_id_q   <= IDLE_ID;
      cfg_data_q <= 8'h00;
      tracing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      send_cnt_q <= send_cnt_d;
      cfg_id_q   <= cfg_id_d;
      cfg_data_q <= cfg_data_d;
      tracing_q  <= tracing_d;
    end
  end

  // Pointers, counts and the in-progress frame; reset discards everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_wr_ptr_q    <= '0;
      buf_rd_ptr_q    <= '0;
      bytes_stored_q  <= '0;
      desc_wr_ptr_q   <= '0;
      desc_rd_ptr_q   <= '0;
      frames_queued_q <= '0;
      in_frame_q      <= 1'b0;
      cur_id_q        <= 8'h00;
      cur_len_q       <= '0;
      frame_err_q     <= 1'b0;
    end else begin
      buf_wr_ptr_q    <= buf_wr_ptr_d;
      buf_rd_ptr_q    <= buf_rd_ptr_d;
      bytes_stored_q  <= bytes_stored_d;
      desc_wr_ptr_q   <= desc_wr_ptr_d;
      desc_rd_ptr_q   <= desc_rd_ptr_d;
      frames_queued_q <= frames_queued_d;
      in_frame_q      <= in_frame_d;
      cur_id_q        <= cur_id_d;
      cur_len_q       <= cur_len_d;
      frame_err_q     <= frame_err_d;
    end
  end

  // Storage writes: a byte on every stored transfer, a descriptor on cfg_last.
  always_ff @(posedge clk) begin
    if (store) buf_mem[buf_wr_ptr_q] <= cfg_byte;
    if (desc_push) begin
      desc_id_mem[desc_wr_ptr_q]  <= frame_id;
      desc_len_mem[desc_wr_ptr_q] <= frame_len;
    end
  end

endmodule

// File: doc/config_stream_transmitter.md
Name: config_stream_transmitter

Overview:
- Drives the shared configId/configData configuration bus that every firmware-programmable building block (vector ALUs, filters, reducers) listens to.
- The host pushes framed configuration images byte by byte. The transmitter buffers each frame until it is complete, stops tracing, then emits the frame as one contiguous run of bytes under the target block's ID. Contiguity is required because receivers increment their byte counter every cycle their ID is present.
- Between frames it inserts idle IDs so that receivers reset their byte counters.

Parameters:
- IDLE_ID, 8'hFF: configId value driven when no frame is being sent; no block may use this ID.
- BUF_DEPTH, 128: byte buffer depth; power of 2.
- DESC_DEPTH, 4: number of completed frames that can be queued; power of 2.
- MAX_FRAME, 64: maximum bytes per frame; must be ≤ BUF_DEPTH.
- QUIESCE_CYCLES, 4: idle cycles after tracing drops, before the first byte, so the datapath pipeline can drain.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- cfg_valid, input, 1: host byte valid.
- cfg_ready, output, 1: transmitter can accept a byte.
- cfg_byte, input, 8: configuration byte.
- cfg_target_id, input, 8: target block ID; sampled on the first byte of a frame only.
- cfg_last, input, 1: marks the final byte of a frame.
- tracing_req, input, 1: host wants tracing enabled.
- tracing, output, 1: tracing enable broadcast to all blocks.
- configId, output, 8: configuration bus ID.
- configData, output, 8: configuration bus data.
- busy, output, 1: high when the FSM is not in IDLE or any frame is queued.
- frame_err, output, 1: sticky truncation flag; cleared only by reset.

Behaviour:
- Reset values (asynchronous): configId=IDLE_ID, configData=0, tracing=0, busy=0, frame_err=0, FSM in IDLE, all buffer pointers and counts 0.
- cfg_ready = !reset & (bytes_stored < BUF_DEPTH) & (frames_queued < DESC_DEPTH). A byte transfers when cfg_valid & cfg_ready.
- Frame assembly:
  - The first accepted byte of a frame latches target_id and sets length to 1; each further byte increments length.
  - Accepting cfg_last pushes the descriptor {target_id, length} into the descriptor FIFO in the same cycle.
  - A frame of length 1 (cfg_last on the first byte) is legal.
- Truncation:
  - Bytes beyond MAX_FRAME are accepted but discarded, and frame_err is set.
  - The frame is still queued, with length = MAX_FRAME.
- FSM states: IDLE, QUIESCE, SEND, GAP. All outputs are registered.
- IDLE:
  - configId=IDLE_ID, configData=0, tracing follows tracing_req with 1 cycle of latency.
  - If frames_queued>0: set tracing=0 next cycle, load counter=QUIESCE_CYCLES, go to QUIESCE.
  - If tracing was already 0 (tracing_req low) on entry, the QUIESCE wait still applies.
- QUIESCE:
  - configId=IDLE_ID, tracing=0; decrement counter.
  - When counter reaches 0, go to SEND.
- SEND:
  - Pop one buffered byte per cycle with no bubbles, driving configId=desc.target_id and configData=byte.
  - Exactly desc.length cycles, after which the descriptor is popped.
  - Host pushes may proceed concurrently; a simultaneous push and pop on the buffer are both honoured, and counts stay exact.
- GAP:
  - Exactly one cycle with configId=IDLE_ID and configData=0.
  - If another frame is queued, go to SEND with no further quiesce; otherwise go to IDLE.
- Latency: cfg_last accepted at cycle t with the FSM in IDLE gives tracing=0 at t+1. The first byte appears at t+2+QUIESCE_CYCLES (t+6 at defaults).
- Back-to-back frames to the same ID are separated by the GAP cycle, so each receiver restarts at byte 0.
- tracing stays 0 from IDLE exit until the cycle after returning to IDLE, regardless of tracing_req.
- Buffer and descriptor FIFO pointers wrap modulo depth.
- Reset mid-SEND:
  - Immediately forces IDLE_ID on configId and discards all buffered and partial frames.
  - A receiver left mid-frame resets its counter on seeing the idle ID.

Test Plan:
- Single frame, target 0x03, bytes 0x10..0x14, tracing_req=1:
  - tracing falls at t+1.
  - configId=0x03 with data 0x10,0x11,0x12,0x13,0x14 on cycles t+6..t+10.
  - configId=0xFF at t+11.
  - tracing=1 at t+13.
- Two queued frames (ID 0x01 with 3 bytes, ID 0x02 with 2 bytes) → 3 cycles of 0x01, exactly 1 cycle of 0xFF, 2 cycles of 0x02, with no second quiesce.
- Host stalls mid-frame (gaps between cfg_valid pulses) → nothing is emitted until cfg_last; the emitted run is still contiguous.
- Frame of 70 bytes with MAX_FRAME=64 → 64 bytes emitted, frame_err=1 and sticky, the next frame is sent correctly.
- Fill the buffer to 128 bytes across complete frames → cfg_ready=0; ready reasserts the cycle after the first SEND pop, with no lost or duplicated bytes.
- Assert reset during SEND byte 2 of a 5-byte frame → configId=0xFF immediately, busy=0, no further bytes emitted after release.
